alu_serial_ctrl: RTL and testbench
==================================

# alu_serial_ctrl

Bit-serial ALU sequencer that drives a single 1-bit ALU slice across a WIDTH-bit word, one bit per clock, LSB first. It accepts a full operand pair plus a 6-bit MIPS funct code over a valid/ready handshake. It supplies the slice's Signal, invertB, cin and Less controls each cycle, carries ripple state between cycles, and returns a WIDTH-bit result with zero/overflow/error flags over a second valid/ready handshake. It is the area-minimal alternative to a 32-slice ripple ALU in the datapath.

## Interface
- WIDTH, 32, operand/result width; legal range 2..64
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  high only in IDLE
- dataA  in  WIDTH  operand A, sampled on input handshake
- dataB  in  WIDTH  operand B, sampled on input handshake
- funct  in  6  AND=36, OR=37, ADD=32, SUB=34, SLT=42
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- result  out  WIDTH  operation result
- zero  out  1  result == 0
- overflow  out  1  signed overflow; ADD/SUB only, else 0
- err  out  1  funct not in supported set

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - Latch A, B and funct.
  - Set invertB = (funct==SUB || funct==SLT) and carry register = invertB.
  - Set bit counter = 0 and clear the result shift register.
  - Go to RUN if funct is supported; otherwise set err=1, result=0 and go directly to DONE.
- RUN: each cycle presents bit A[cnt], B[cnt], carry, invertB and Signal=funct to the slice; Less is tied 0.
  - Slice sum is shifted into result at the MSB end (shift right), so after WIDTH cycles bit 0 sits at result[0].
  - Carry register takes the slice cout.
  - On the bit WIDTH-1 cycle, also capture cin_msb (the carry into the MSB) and sum_msb.
- RUN exit (edge that consumes bit WIDTH-1), go to DONE:
  - ovf = cin_msb ^ cout_msb.
  - ADD/SUB: overflow=ovf.
  - SLT: result = {WIDTH-1 zeros, sum_msb ^ ovf}, overflow=0.
  - AND/OR: overflow=0.
- DONE: out_valid=1 and outputs held stable until out_valid&out_ready; then go to IDLE, with out_valid and err cleared.
- zero is combinational from the result register and is valid whenever out_valid=1.
- Carry chain is unsigned modulo 2^WIDTH; final carry-out is discarded.
- in_valid in RUN/DONE is ignored (in_ready=0); inputs change freely outside the handshake.

## Timing
- Reset (async assert, sync release on rst_n rising): state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, overflow=0, err=0, counter=0, carry=0.
- Reset mid-RUN or mid-DONE aborts the operation immediately; the pending result is lost and no output handshake occurs.
- Supported funct: input handshake at edge E0; out_valid rises after edge E0+WIDTH (WIDTH RUN cycles).
- Unsupported funct: out_valid rises after E0+1.
- Output handshake at edge Ek means state=IDLE and in_ready=1 from Ek+1. Minimum spacing between input handshakes is WIDTH+2 cycles (supported funct, out_ready held high).
- Counter is log2(WIDTH)+1 bits and never wraps; RUN exits on cnt==WIDTH-1.

## Structure
- Shared package alu_pkg holds:
  - funct localparams AND/OR/ADD/SUB/SLT (shared with the slice);
  - the state enum IDLE/RUN/DONE;
  - an is_supported(funct) function.
- One sub-module: the existing 1-bit slice ALU_1bit, instantiated once. Its cout feeds the carry register, and its sum feeds the shifter.
- No other hierarchy; the FSM, counter, shifter and flag logic live in alu_serial_ctrl.

## Test plan
- Reset with no traffic: in_ready=1, out_valid=0, result=0, zero=1, overflow=0, err=0. Assert rst_n low mid-RUN: same values within the same cycle, with no out_valid afterwards.
- ADD 0x7FFFFFFF + 0x00000001:
  - result 0x80000000, overflow=1, zero=0;
  - out_valid exactly 32 cycles after the accepting edge.
- SUB 5 − 5: result 0, zero=1, overflow=0.
- SUB 0x80000000 − 1: result 0x7FFFFFFF, overflow=1.
- SLT cases:
  - 0xFFFFFFFF vs 0x00000001: result 1.
  - 0x7FFFFFFF vs 0x80000000: result 0 (overflow-corrected).
  - 3 vs 3: result 0, zero=1.
- AND 0xF0F0F0F0 with 0xFF00FF00: result 0xF000F000. OR of the same operands: result 0xFFF0FFF0. Both with overflow=0.
- Unsupported funct 0x00:
  - err=1, result=0, out_valid one cycle after accept.
  - Hold out_ready=0 for 5 cycles: all outputs stable, in_ready=0, and a new in_valid is not accepted.
  - Release out_ready: next request is accepted the cycle after.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer and its 1-bit slice.
// Holds funct codes, controller states and the supported-op check.
package alu_pkg;

  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_SLT = 6'd42;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_supported(input logic [5:0] f);
    return (f == FN_ADD) || (f == FN_SUB) ||
           (f == FN_AND) || (f == FN_OR)  ||
           (f == FN_SLT);
  endfunction

  function automatic logic needs_invert(input logic [5:0] f);
    return (f == FN_SUB) || (f == FN_SLT);
  endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle for the bit-serial ALU sequencer.
// Two valid/ready handshakes: operands in, result and flags out.
interface alu_serial_ctrl_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic [5:0]       funct;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             err;

  modport master (
    output in_valid, dataA, dataB, funct,
    output out_ready,
    input  in_ready,
    input  out_valid, result, zero,
    input  overflow, err
  );

  modport slave (
    input  in_valid, dataA, dataB, funct,
    input  out_ready,
    output in_ready,
    output out_valid, result, zero,
    output overflow, err
  );

endinterface

// File: rtl/ALU_1bit.sv
// One bit of a MIPS ripple ALU: AND/OR/ADD/SUB/SLT selected by Signal.
// o_set exposes the raw adder sum so the MSB can form the SLT bit.
module ALU_1bit
  import alu_pkg::*;
(
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_invert_b,
  input  logic       i_cin,
  input  logic       i_less,
  input  logic [5:0] i_signal,
  output logic       o_sum,
  output logic       o_set,
  output logic       o_cout
);

  logic w_b;
  logic w_add;

  assign w_b    = i_b ^ i_invert_b;
  assign w_add  = i_a ^ w_b ^ i_cin;
  assign o_set  = w_add;
  assign o_cout = (i_a & w_b) | (i_cin & (i_a ^ w_b));

  // Select the slice output for the current operation.
  always_comb begin
    o_sum = 1'b0;
    unique case (1'b1)
      (i_signal == FN_AND): o_sum = i_a & w_b;
      (i_signal == FN_OR):  o_sum = i_a | w_b;
      (i_signal == FN_ADD): o_sum = w_add;
      (i_signal == FN_SUB): o_sum = w_add;
      (i_signal == FN_SLT): o_sum = i_less;
      default:              o_sum = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: walks one ALU_1bit slice over a WIDTH-bit word,
// LSB first, and returns result plus zero/overflow/err flags.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         rst_n,
  alu_serial_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [5:0]       r_funct;
  logic             r_invb;
  logic             r_carry;
  logic             r_ovf;
  logic             r_err;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_sum;
  logic             w_set;
  logic             w_cout;
  logic             w_ovf;
  logic             w_arith;
  logic [WIDTH-1:0] w_shift;

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_ovf    = r_carry ^ w_cout;
  assign w_arith  = (r_funct == FN_ADD) || (r_funct == FN_SUB);
  assign w_shift  = {w_sum, r_result[WIDTH-1:1]};

  ALU_1bit u_slice (
    .i_a        (r_a[0]),
    .i_b        (r_b[0]),
    .i_invert_b (r_invb),
    .i_cin      (r_carry),
    .i_less     (1'b0),
    .i_signal   (r_funct),
    .o_sum      (w_sum),
    .o_set      (w_set),
    .o_cout     (w_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: unsupported ops skip RUN and report err directly.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept)
          w_next = is_supported(bus.funct) ? RUN : DONE;
      end
      RUN: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand shifters, ripple carry, bit counter, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_funct  <= '0;
      r_invb   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a      <= bus.dataA;
      r_b      <= bus.dataB;
      r_funct  <= bus.funct;
      r_invb   <= needs_invert(bus.funct);
      r_carry  <= needs_invert(bus.funct);
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_err    <= !is_supported(bus.funct);
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        if (r_funct == FN_SLT)
          r_result <= {{(WIDTH-1){1'b0}}, w_set ^ w_ovf};
        else
          r_result <= w_shift;
        r_ovf <= w_arith ? w_ovf : 1'b0;
      end else begin
        r_result <= w_shift;
      end
    end else if ((r_state == DONE) && bus.out_ready) begin
      r_err <= 1'b0;
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.result    = r_result;
  assign bus.zero      = ~|r_result;
  assign bus.overflow  = r_ovf;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl: directed MIPS ALU cases plus
// random traffic compared against a plain-arithmetic reference model.
module tb_alu_serial_ctrl;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_chk = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_serial_ctrl_if #(.WIDTH(W)) bus ();

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [5:0] f, output logic [W-1:0] r,
                       output logic v, output logic e);
    r = '0;
    v = 1'b0;
    e = 1'b0;
    case (f)
      FN_ADD: begin
        r = a + b;
        v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      FN_SUB: begin
        r = a - b;
        v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      FN_SLT: r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      FN_AND: r = a & b;
      FN_OR:  r = a | b;
      default: e = 1'b1;
    endcase
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [5:0] f, input string tag);
    logic [W-1:0] er;
    logic ev, ee;
    int lat, el;
    model(a, b, f, er, ev, ee);
    el = ee ? 0 : W;
    bus.dataA = a;
    bus.dataB = b;
    bus.funct = f;
    bus.in_valid = 1'b1;
    n_chk++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL %s in_ready got %b want 1", tag, bus.in_ready);
    else n_pass++;
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.dataA = $urandom;
    bus.dataB = $urandom;
    bus.funct = 6'($urandom);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < W + 10) begin
      @(posedge clk); #1;
      lat++;
    end
    n_chk++;
    if (lat !== el)
      $display("FAIL %s latency got %0d want %0d", tag, lat, el);
    else n_pass++;
    n_chk++;
    if (bus.result !== er)
      $display("FAIL %s result got %h want %h", tag, bus.result, er);
    else n_pass++;
    n_chk++;
    if (bus.zero !== (er == '0))
      $display("FAIL %s zero got %b want %b", tag, bus.zero, er == '0);
    else n_pass++;
    n_chk++;
    if (bus.overflow !== ev)
      $display("FAIL %s overflow got %b want %b", tag, bus.overflow, ev);
    else n_pass++;
    n_chk++;
    if (bus.err !== ee)
      $display("FAIL %s err got %b want %b", tag, bus.err, ee);
    else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01)
      $display("FAIL %s post-handshake ov/ir got %b want 01", tag,
               {bus.out_valid, bus.in_ready});
    else n_pass++;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.dataA = '0;
    bus.dataB = '0;
    bus.funct = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.in_ready, bus.out_valid, bus.result, bus.zero,
         bus.overflow, bus.err} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_hold ir=%b ov=%b res=%h z=%b o=%b e=%b want 1 0 0 1 0 0",
               bus.in_ready, bus.out_valid, bus.result, bus.zero,
               bus.overflow, bus.err);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({bus.in_ready, bus.out_valid, bus.zero, bus.err} !== 4'b1010)
      $display("FAIL reset_release ir/ov/z/e got %b want 1010",
               {bus.in_ready, bus.out_valid, bus.zero, bus.err});
    else n_pass++;
  endtask

  task automatic test_directed();
    run_op(32'h7FFFFFFF, 32'h00000001, FN_ADD, "add_ovf");
    run_op(32'd5, 32'd5, FN_SUB, "sub_zero");
    run_op(32'h80000000, 32'h00000001, FN_SUB, "sub_ovf");
    run_op(32'hFFFFFFFF, 32'h00000001, FN_SLT, "slt_neg");
    run_op(32'h7FFFFFFF, 32'h80000000, FN_SLT, "slt_ovfcorr");
    run_op(32'd3, 32'd3, FN_SLT, "slt_eq");
    run_op(32'hF0F0F0F0, 32'hFF00FF00, FN_AND, "and");
    run_op(32'hF0F0F0F0, 32'hFF00FF00, FN_OR, "or");
  endtask

  task automatic test_unsupported_stall();
    bus.out_ready = 1'b0;
    bus.dataA = $urandom;
    bus.dataB = $urandom;
    bus.funct = 6'h00;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({bus.out_valid, bus.err, bus.result, bus.zero, bus.in_ready} !==
        {1'b1, 1'b1, 32'h0, 1'b1, 1'b0})
      $display("FAIL unsup_first ov=%b e=%b res=%h z=%b ir=%b want 1 1 0 1 0",
               bus.out_valid, bus.err, bus.result, bus.zero, bus.in_ready);
    else n_pass++;
    bus.funct = FN_ADD;
    bus.dataA = 32'd3;
    bus.dataB = 32'd4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({bus.out_valid, bus.err, bus.result, bus.zero,
           bus.overflow, bus.in_ready} !==
          {1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0})
        $display("FAIL unsup_stall%0d ov=%b e=%b res=%h z=%b o=%b ir=%b", i,
                 bus.out_valid, bus.err, bus.result, bus.zero,
                 bus.overflow, bus.in_ready);
      else n_pass++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({bus.in_ready, bus.out_valid, bus.err} !== 3'b100)
      $display("FAIL unsup_release ir/ov/e got %b want 100",
               {bus.in_ready, bus.out_valid, bus.err});
    else n_pass++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_chk++;
    if (bus.in_ready !== 1'b0)
      $display("FAIL unsup_next_accept in_ready got %b want 0", bus.in_ready);
    else n_pass++;
    for (int i = 0; i < W + 10 && bus.out_valid !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    n_chk++;
    if ({bus.out_valid, bus.result} !== {1'b1, 32'd7})
      $display("FAIL unsup_next_result ov=%b res=%h want 1 00000007",
               bus.out_valid, bus.result);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int c0;
    run_op(32'd100, 32'd23, FN_ADD, "b2b_0");
    c0 = acc_cyc;
    run_op(32'd100, 32'd23, FN_SUB, "b2b_1");
    n_chk++;
    if (acc_cyc - c0 !== W + 2)
      $display("FAIL b2b_spacing got %0d want %0d", acc_cyc - c0, W + 2);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [5:0] f;
    logic [W-1:0] sp [5];
    sp[0] = 32'h0;
    sp[1] = 32'h1;
    sp[2] = 32'h7FFFFFFF;
    sp[3] = 32'h80000000;
    sp[4] = 32'hFFFFFFFF;
    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 4)] : $urandom;
      case ($urandom_range(0, 5))
        0: f = FN_ADD;
        1: f = FN_SUB;
        2: f = FN_AND;
        3: f = FN_OR;
        4: f = FN_SLT;
        default: f = 6'($urandom);
      endcase
      run_op(a, b, f, $sformatf("rand%0d_f%0d", i, f));
    end
  endtask

  task automatic test_reset_mid_run();
    logic seen;
    bus.dataA = 32'h12345678;
    bus.dataB = 32'h11111111;
    bus.funct = FN_ADD;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.in_ready, bus.out_valid, bus.result, bus.zero,
         bus.overflow, bus.err} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_mid_run ir=%b ov=%b res=%h z=%b o=%b e=%b",
               bus.in_ready, bus.out_valid, bus.result, bus.zero,
               bus.overflow, bus.err);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0)
      $display("FAIL reset_no_out out_valid seen got %b want 0", seen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_unsupported_stall();
    test_back_to_back();
    test_random();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
